disk_dma_ctrl: RTL and testbench
================================

// Module: disk_dma_ctrl
// PURPOSE
//  Single-channel DMA sequencer between the track/sector hard disk and the word memory.
//  Copies cnt words disk->mem (LOAD, boot/program load) or mem->disk (STORE), one word per clock.
//  Sits beside the CPU; owns the disk port while busy. CPU starts a job and polls or waits for done.
// PARAMETERS
//  SECTORS   2     sectors per track; disk word index = track*SECTORS + sector
//  TRACKS    2     number of tracks; disk holds TRACKS*SECTORS words
//  MEM_AW    10    memory word-address width
//  CNT_W     16    transfer-length width
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       job request, sampled only in IDLE
//  dir        in   1       0=LOAD disk->mem, 1=STORE mem->disk (latched at start)
//  trk0       in   32      start track (latched at start)
//  sec0       in   32      start sector, must be < SECTORS (latched at start)
//  mem0       in   MEM_AW  start memory word address (latched at start)
//  cnt        in   CNT_W   words to move; 0 = no-op job
//  busy       out  1       job in progress
//  done       out  1       one-cycle pulse: job finished OK
//  err        out  1       one-cycle pulse: job aborted (range error)
//  disk_s     out  32      disk track select
//  disk_t     out  32      disk sector select
//  disk_we    out  1       disk write enable
//  disk_wdata out  32      disk write data
//  disk_rdata in   32      disk read data, combinational from disk_s/disk_t
//  mem_addr   out  MEM_AW  memory word address
//  mem_we     out  1       memory write enable
//  mem_wdata  out  32      memory write data
//  mem_rdata  in   32      memory read data, combinational from mem_addr
// BEHAVIOUR
//  Reset: state IDLE; busy/done/err/disk_we/mem_we = 0; disk_s/disk_t/mem_addr/data outs = 0.
//  States: IDLE -> XFER (start & cnt!=0 & range ok) | DONE (start & cnt==0) | ERR (start & bad range).
//   XFER -> XFER while remaining>1; XFER -> DONE after last word. DONE/ERR -> IDLE after 1 cycle.
//  Range ok: sec0 < SECTORS and trk0*SECTORS+sec0+cnt <= TRACKS*SECTORS (compute wide, no wrap).
//  XFER, each cycle: LOAD: mem_we=1, mem_wdata=disk_rdata; STORE: disk_we=1, disk_wdata=mem_rdata.
//   Write enables combinationally = (state==XFER) & dir-select; never asserted outside XFER.
//  Address step per word: mem_addr+1 (wraps mod 2^MEM_AW); sector+1, at SECTORS wrap to 0 and track+1.
//  Latency: job of N>0 words -> busy high N cycles starting cycle after start; done on cycle N+1.
//  busy = (state==XFER); done = (state==DONE); err = (state==ERR). start while busy is ignored.
//  disk_s/disk_t/mem_addr hold last values in IDLE (no spurious write: enables low).
//  rst_n low mid-job: immediate abort, enables drop asynchronously, no done/err; partial data stays.
// CONFIGURATION
//  DISK_DMA_CHECKSUM_EN defined: adds output csum[31:0]; cleared at job accept, += every word
//   moved (mod 2^32); valid and stable from the done pulse until next accepted start; reset 0.
//  Not defined: no csum port, no adder; all other behaviour identical.
// STRUCTURE
//  Package disk_dma_pkg: state enum {IDLE,XFER,DONE,ERR}, DIR_LOAD/DIR_STORE constants.
//  Sub-module disk_addr_step: track/sector incrementer with SECTORS wrap (reused by CPU disk path).
//  Top: FSM, remaining counter (CNT_W), mem address counter, optional checksum register.
// TESTING
//  LOAD trk0=0 sec0=0 cnt=4, disk={A,B,C,D} -> mem[0..3]=A..D, busy 4 cycles, done on cycle 5.
//  STORE trk0=0 sec0=1 cnt=2 mem0=8 -> disk idx1,2 = mem[8],mem[9]; disk_s steps 0->1, disk_t 1->0.
//  cnt=0 start -> done pulse next cycle, busy never high, no write enables.
//  trk0=1 sec0=1 cnt=2 (needs idx 3,4) -> err pulse, no writes, returns IDLE.
//  rst_n low during XFER of cnt=4 after 2 words -> only 2 words written, outputs reset, no done.
//  start pulsed while busy -> ignored; CHECKSUM_EN: LOAD {1,2,3,4} -> csum=10 at done.

Source files
------------

// File: rtl/disk_dma_pkg.sv
// Shared types and helpers for the disk<->memory DMA sequencer.
package disk_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  // Wide arithmetic so a huge track or count can never wrap back into range.
  function automatic logic range_ok(input logic [31:0] trk,
                                    input logic [31:0] sec,
                                    input logic [63:0] len,
                                    input logic [31:0] sectors,
                                    input logic [31:0] tracks);
    logic [65:0] last;
    logic [65:0] cap;
    last = 66'(trk) * 66'(sectors) + 66'(sec) + 66'(len);
    cap  = 66'(tracks) * 66'(sectors);
    return (sec < sectors) && (last <= cap);
  endfunction

endpackage

// File: rtl/disk_addr_step.sv
// Track/sector incrementer: advances one sector, wrapping to the next track at SECTORS.
module disk_addr_step #(
  parameter int SECTORS = 2
) (
  input  logic [31:0] trk,
  input  logic [31:0] sec,
  output logic [31:0] trk_nxt,
  output logic [31:0] sec_nxt
);

  logic [31:0] sec_inc;

  always_comb begin
    sec_inc = sec + 32'd1;
    trk_nxt = trk;
    sec_nxt = sec_inc;
    if (sec_inc >= 32'(SECTORS)) begin
      sec_nxt = '0;
      trk_nxt = trk + 32'd1;
    end
  end

endmodule

// File: rtl/disk_dma_ctrl.sv
// Single-channel DMA sequencer: moves cnt words disk->mem (LOAD) or mem->disk (STORE).
// Optional running word checksum output enabled by DISK_DMA_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; address registers hold their last values
// XFER  | moving one word per clock, busy high
// DONE  | one-cycle done pulse
// ERR   | one-cycle err pulse, job rejected for range
module disk_dma_ctrl
  import disk_dma_pkg::*;
#(
  parameter int SECTORS = 2,
  parameter int TRACKS  = 2,
  parameter int MEM_AW  = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [31:0]       trk0,
  input  logic [31:0]       sec0,
  input  logic [MEM_AW-1:0] mem0,
  input  logic [CNT_W-1:0]  cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       disk_s,
  output logic [31:0]       disk_t,
  output logic              disk_we,
  output logic [31:0]       disk_wdata,
  input  logic [31:0]       disk_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef DISK_DMA_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  state_e            state;
  logic              dir_q;
  logic [31:0]       trk_q;
  logic [31:0]       sec_q;
  logic [31:0]       trk_nxt;
  logic [31:0]       sec_nxt;
  logic [MEM_AW-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic              xfer;
  logic              is_load;
  logic              ok;

  disk_addr_step #(.SECTORS(SECTORS)) u_step (
    .trk     (trk_q),
    .sec     (sec_q),
    .trk_nxt (trk_nxt),
    .sec_nxt (sec_nxt)
  );

  assign ok      = range_ok(trk0, sec0, 64'(cnt), 32'(SECTORS), 32'(TRACKS));
  assign xfer    = (state == XFER);
  assign is_load = (dir_q == DIR_LOAD);

  // Enables decode straight from state so an async reset drops them immediately.
  assign mem_we     = xfer & is_load;
  assign disk_we    = xfer & ~is_load;
  assign mem_wdata  = mem_we  ? disk_rdata : '0;
  assign disk_wdata = disk_we ? mem_rdata  : '0;

  assign busy     = xfer;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign disk_s   = trk_q;
  assign disk_t   = sec_q;
  assign mem_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dir_q  <= DIR_LOAD;
      trk_q  <= '0;
      sec_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cnt == '0) begin
              state <= DONE;
            end else if (!ok) begin
              state <= ERR;
            end else begin
              state  <= XFER;
              dir_q  <= dir;
              trk_q  <= trk0;
              sec_q  <= sec0;
              addr_q <= mem0;
              rem_q  <= cnt;
            end
          end
        end
        XFER: begin
          trk_q  <= trk_nxt;
          sec_q  <= sec_nxt;
          addr_q <= addr_q + MEM_AW'(1);
          rem_q  <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISK_DMA_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == IDLE && start && (cnt == '0 || ok)) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum + (is_load ? disk_rdata : mem_rdata);
    end
  end
`endif

endmodule

// File: tb/tb_disk_dma_ctrl.sv
// Scoreboard bench for disk_dma_ctrl: reference model pushes expected writes and job endings,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_disk_dma_ctrl;

  localparam int SECTORS = 2;
  localparam int TRACKS  = 2;
  localparam int MEM_AW  = 10;
  localparam int CNT_W   = 16;
  localparam int DWORDS  = SECTORS * TRACKS;
  localparam int MWORDS  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              dir = 1'b0;
  logic [31:0]       trk0 = '0;
  logic [31:0]       sec0 = '0;
  logic [MEM_AW-1:0] mem0 = '0;
  logic [CNT_W-1:0]  cnt = '0;
  logic              busy, done, err, disk_we, mem_we;
  logic [31:0]       disk_s, disk_t, disk_wdata, disk_rdata, mem_wdata, mem_rdata;
  logic [MEM_AW-1:0] mem_addr;
`ifdef DISK_DMA_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  logic [31:0] disk_arr [DWORDS];
  logic [31:0] mem_arr  [MWORDS];
  logic [31:0] ref_disk [DWORDS];
  logic [31:0] ref_mem  [MWORDS];

  typedef struct { bit to_disk; int unsigned idx; logic [31:0] data; } wr_t;
  typedef struct { bit is_err; int unsigned busy_n; logic [31:0] sum; } ev_t;
  wr_t wq[$];
  ev_t eq[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  disk_dma_ctrl #(.SECTORS(SECTORS), .TRACKS(TRACKS), .MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dir        (dir),
    .trk0       (trk0),
    .sec0       (sec0),
    .mem0       (mem0),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .disk_s     (disk_s),
    .disk_t     (disk_t),
    .disk_we    (disk_we),
    .disk_wdata (disk_wdata),
    .disk_rdata (disk_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DISK_DMA_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  // Environment memories: combinational reads, writes on the rising edge.
  always_comb begin
    disk_rdata = 32'hdead_beef;
    if (disk_s < 32'(TRACKS) && disk_t < 32'(SECTORS))
      disk_rdata = disk_arr[2'(disk_s * 32'(SECTORS) + disk_t)];
    mem_rdata = mem_arr[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] = mem_wdata;
    if (disk_we && disk_s < 32'(TRACKS) && disk_t < 32'(SECTORS))
      disk_arr[2'(disk_s * 32'(SECTORS) + disk_t)] = disk_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT writes or ends a job.
  int unsigned busy_n = 0;
  wr_t w;
  ev_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_n = 0;
    end else begin
      if (busy) busy_n++;
      if (mem_we || disk_we) begin
        if (wq.size() == 0) begin
          fail("unexpected_write");
        end else begin
          w = wq.pop_front();
          check("write_target", 64'(disk_we), 64'(w.to_disk));
          check("write_addr", disk_we ? 64'(disk_s * 32'(SECTORS) + disk_t) : 64'(mem_addr), 64'(w.idx));
          check("write_data", disk_we ? 64'(disk_wdata) : 64'(mem_wdata), 64'(w.data));
        end
      end
      if (done || err) begin
        if (eq.size() == 0) begin
          fail("unexpected_job_end");
        end else begin
          e = eq.pop_front();
          check("end_kind_err", 64'(err), 64'(e.is_err));
          check("busy_cycles", 64'(busy_n), 64'(e.busy_n));
`ifdef DISK_DMA_CHECKSUM_EN
          if (done) check("csum", 64'(csum), 64'(e.sum));
`endif
        end
        busy_n = 0;
      end
    end
  end

  // Reference model: plain index arithmetic over the disk/memory word arrays.
  task automatic run_job(input logic d, input int t, input int s, input int m, input int n,
                         input bit poke);
    int    base;
    int    k;
    int    exp_lat;
    bit    bad;
    int    ma;
    wr_t   x;
    ev_t   ev;
    logic [31:0] sum;
    base = t * SECTORS + s;
    bad  = (n != 0) && (s >= SECTORS || base + n > DWORDS);
    sum  = '0;
    if (n != 0 && !bad) begin
      for (int i = 0; i < n; i++) begin
        ma = (m + i) % MWORDS;
        if (d == 1'b0) begin
          x.to_disk = 1'b0; x.idx = ma; x.data = ref_disk[base + i];
          ref_mem[ma] = x.data;
        end else begin
          x.to_disk = 1'b1; x.idx = base + i; x.data = ref_mem[ma];
          ref_disk[base + i] = x.data;
        end
        sum += x.data;
        wq.push_back(x);
      end
    end
    ev.is_err = bad;
    ev.busy_n = (n == 0 || bad) ? 0 : n;
    ev.sum    = sum;
    eq.push_back(ev);
    exp_lat = (n == 0 || bad) ? 1 : n + 1;

    @(posedge clk); #1;
    dir = d; trk0 = t; sec0 = s; mem0 = MEM_AW'(m); cnt = CNT_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (poke && k == 1) begin
        start = 1'b1; dir = ~d; trk0 = 0; sec0 = 0; cnt = 7; mem0 = '0;
      end
      if (poke && k == 2) start = 1'b0;
      if (done || err) break;
    end
    if (k >= 60) begin
      fail("job_timeout");
    end else begin
      check("latency", 64'(k), 64'(exp_lat));
      @(negedge clk);
      check("pulse_one_cycle", {62'd0, done, err}, 64'd0);
      check("idle_not_busy", 64'(busy), 64'd0);
    end
    check("writes_drained", 64'(wq.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    for (int i = 0; i < DWORDS; i++) begin
      disk_arr[i] = 32'(i + 1);
      ref_disk[i] = 32'(i + 1);
    end
    for (int i = 0; i < MWORDS; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end

    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", {62'd0, done, err}, 64'd0);
    check("rst_we", {62'd0, mem_we, disk_we}, 64'd0);
    check("rst_addr", {disk_s, 22'd0, mem_addr}, 64'd0);
    check("rst_disk_t", 64'(disk_t), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(1'b0, 0, 0, 0, 4, 1'b0);
    for (int i = 0; i < 4; i++) check("load_mem", 64'(mem_arr[i]), 64'(i + 1));
    run_job(1'b1, 0, 1, 8, 2, 1'b0);
    run_job(1'b0, 1, 0, 3, 0, 1'b0);
    run_job(1'b0, 1, 1, 20, 2, 1'b0);
    run_job(1'b1, 0, 2, 20, 1, 1'b0);
    run_job(1'b0, 0, 0, 500, 4, 1'b1);
    run_job(1'b0, 0, 1, MWORDS - 2, 3, 1'b0);

    for (int j = 0; j < 40; j++) begin
      run_job(1'($urandom), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
              int'($urandom_range(MWORDS - 1, 0)), int'($urandom_range(5, 0)), 1'b0);
    end

    // Abort after two words: only those two may land, no ending pulse.
    for (int i = 0; i < 2; i++) begin
      wr_t x;
      x.to_disk = 1'b0; x.idx = 100 + i; x.data = ref_disk[i];
      ref_mem[100 + i] = x.data;
      wq.push_back(x);
    end
    @(posedge clk); #1;
    dir = 1'b0; trk0 = 0; sec0 = 0; mem0 = MEM_AW'(100); cnt = CNT_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_we", {62'd0, mem_we, disk_we}, 64'd0);
    check("abort_addr", {disk_s, 22'd0, mem_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_writes", 64'(wq.size()), 64'd0);
    check("abort_no_end", 64'(eq.size()), 64'd0);

    mism = 0;
    for (int i = 0; i < MWORDS; i++) if (mem_arr[i] !== ref_mem[i]) mism++;
    check("final_mem_mismatches", 64'(mism), 64'd0);
    mism = 0;
    for (int i = 0; i < DWORDS; i++) if (disk_arr[i] !== ref_disk[i]) mism++;
    check("final_disk_mismatches", 64'(mism), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
